// File: rtl/pc_pipe.sv
// Program-counter unit: fetch address generation, PC pipeline to the resolve stage,
// branch/jump redirect with per-stage validity. Optional PC_ALIGN_TRAP_EN traps misaligned targets.
module pc_pipe #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      DEPTH      = 2,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0,
    parameter logic [WIDTH-1:0] TRAP_ADDR  = WIDTH'(32'h0000_0100)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch,
    input  logic [WIDTH-1:0] baddr,
    input  logic             jump,
    input  logic [WIDTH-1:0] jaddr,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic [WIDTH-1:0] link,
    output logic             flush,
    output logic             misalign
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(4);

    logic [WIDTH-1:0] pc_q [0:DEPTH];
    logic [DEPTH:0]   v_q;
    logic             redir_q;
    logic [WIDTH-1:0] tgt_q;

    logic             capture;
    logic [WIDTH-1:0] tgt_raw;
    logic [WIDTH-1:0] tgt_next;
    logic             tgt_misaligned;

    // Only a valid resolve-stage instruction may redirect, and only one redirect in flight.
    assign capture        = ~stall & ~redir_q & v_q[DEPTH] & (jump | branch);
    assign tgt_raw        = jump ? jaddr : link + baddr;
    assign tgt_misaligned = |tgt_raw[1:0];

`ifdef PC_ALIGN_TRAP_EN
    logic mis_q;

    assign tgt_next = tgt_misaligned ? TRAP_ADDR : tgt_raw;
    assign misalign = mis_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else if (!stall) begin
            mis_q <= capture & tgt_misaligned;
        end
    end
`else
    logic unused_trap;

    assign tgt_next    = {tgt_raw[WIDTH-1:2], 2'b00};
    assign misalign    = 1'b0;
    assign unused_trap = ^{TRAP_ADDR, tgt_misaligned};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q[0] <= RESET_ADDR;
            for (int i = 1; i <= DEPTH; i++) begin
                pc_q[i] <= '0;
            end
            v_q     <= (DEPTH+1)'(1);
            redir_q <= 1'b0;
            tgt_q   <= '0;
        end else if (!stall) begin
            for (int i = 1; i <= DEPTH; i++) begin
                pc_q[i] <= pc_q[i-1];
            end
            if (redir_q) begin
                pc_q[0] <= tgt_q;
                redir_q <= 1'b0;
            end else begin
                pc_q[0] <= pc_q[0] + STEP;
            end
            v_q <= {v_q[DEPTH-1:0], redir_q | v_q[0]};
            // A capture squashes every stage, overriding the shift above.
            if (capture) begin
                redir_q <= 1'b1;
                tgt_q   <= tgt_next;
                v_q     <= '0;
            end
        end
    end

    assign pc       = pc_q[0];
    assign pc_valid = v_q[0] & ~redir_q;
    assign link     = pc_q[DEPTH] + STEP;
    assign flush    = redir_q;

endmodule

// File: tb/tb_pc_pipe.sv
// Self-checking bench for pc_pipe (WIDTH=32, DEPTH=2): a fetch-history model checked every
// cycle, plus literal expectations from hand-worked sequences. Honors PC_ALIGN_TRAP_EN.
module tb_pc_pipe;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RST_A = 32'h0;
    localparam logic [31:0] TRAP  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1, stall = 1'b0, branch = 1'b0, jump = 1'b0;
    logic [31:0] baddr = '0, jaddr = '0;
    logic [31:0] pc, link;
    logic        pc_valid, flush, misalign;

    int vectors = 0;
    int miscompares = 0;

    pc_pipe #(.WIDTH(32), .DEPTH(DEPTH), .RESET_ADDR(RST_A), .TRAP_ADDR(TRAP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch), .baddr(baddr),
        .jump(jump), .jaddr(jaddr), .pc(pc), .pc_valid(pc_valid), .link(link),
        .flush(flush), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Model: fetch address plus a history of earlier fetches; the oldest entry is the resolve stage.
    typedef struct {
        logic [31:0] a;
        logic        v;
    } fetch_t;

    fetch_t      hist[$];
    logic [31:0] m_pc;
    logic        m_fv, m_pend, m_trap, model_ok = 1'b0;
    logic [31:0] m_tgt;

    task automatic model_step();
        logic [31:0] t;
        logic        take;
        if (reset) begin
            m_pc = RST_A; m_fv = 1'b1; m_pend = 1'b0; m_trap = 1'b0; m_tgt = '0;
            hist.delete();
            for (int i = 0; i < DEPTH; i++) hist.push_back('{a: 32'h0, v: 1'b0});
            model_ok = 1'b1;
        end else if (!stall) begin
            take = !m_pend && hist[0].v && (jump || branch);
            t = jump ? jaddr : hist[0].a + 32'd4 + baddr;
            void'(hist.pop_front());
            hist.push_back('{a: m_pc, v: m_fv});
            if (m_pend) begin
                m_pc = m_tgt; m_fv = 1'b1; m_pend = 1'b0; m_trap = 1'b0;
            end else begin
                m_pc = m_pc + 32'd4;
            end
            if (take) begin
                for (int i = 0; i < DEPTH; i++) hist[i].v = 1'b0;
                m_fv = 1'b0; m_pend = 1'b1;
`ifdef PC_ALIGN_TRAP_EN
                m_trap = (t[1:0] != 2'b00);
                m_tgt  = m_trap ? TRAP : t;
`else
                m_trap = 1'b0;
                m_tgt  = t & ~32'h3;
`endif
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model pc", pc, m_pc);
            chk("model pc_valid", 32'(pc_valid), 32'(m_fv & ~m_pend));
            chk("model flush", 32'(flush), 32'(m_pend));
            chk("model link", link, hist[0].a + 32'd4);
            chk("model misalign", 32'(misalign), 32'(m_pend & m_trap));
        end
    end

    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] ba,
                        input logic j, input logic [31:0] ja);
        reset = r; stall = s; branch = b; baddr = ba; jump = j; jaddr = ja;
        @(posedge clk);
        model_step();
        #1;
        reset = 1'b0; stall = 1'b0; branch = 1'b0; jump = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 32'h40);
        chk("reset pc", pc, 32'h0);
        chk("reset pc_valid", 32'(pc_valid), 1);
        chk("reset flush", 32'(flush), 0);
        chk("reset link", link, 32'h4);
        chk("reset misalign", 32'(misalign), 0);

        for (int k = 1; k <= 4; k++) begin
            idle(1);
            chk("free run pc", pc, 32'(4 * k));
        end
        chk("link at branch", link, 32'd12);

        step(0, 0, 1, 32'h20, 0, 0);
        chk("branch flush", 32'(flush), 1);
        chk("branch pc pending", pc, 32'd20);
        chk("branch pc_valid pending", 32'(pc_valid), 0);
        idle(1);
        chk("branch target", pc, 32'h2C);
        chk("branch target valid", 32'(pc_valid), 1);

        idle(2);
        chk("link before jump", link, 32'h30);
        step(0, 0, 1, 32'h20, 1, 32'h400);
        chk("jump flush", 32'(flush), 1);
        step(0, 0, 1, 32'h20, 0, 0);
        chk("jump wins", pc, 32'h400);
        step(0, 0, 1, 32'h20, 0, 0);
        step(0, 0, 1, 32'h20, 0, 0);
        chk("no early redirect", 32'(flush), 0);
        chk("no early redirect pc", pc, 32'h408);
        step(0, 0, 1, 32'h0, 0, 0);
        chk("second redirect flush", 32'(flush), 1);
        idle(1);
        chk("second redirect pc", pc, 32'h404);

        idle(2);
        step(0, 1, 0, 0, 1, 32'h123);
        chk("stalled jump ignored", 32'(flush), 0);
        step(0, 0, 0, 0, 1, 32'h800);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 0, 0, 0);
            chk("stall flush held", 32'(flush), 1);
            chk("stall pc held", pc, 32'h410);
        end
        idle(1);
        chk("stall redirect applied", pc, 32'h800);
        chk("stall flush cleared", 32'(flush), 0);

        idle(2);
        step(0, 0, 0, 0, 1, 32'h900);
        chk("pending before reset", 32'(flush), 1);
        step(1, 0, 0, 0, 0, 0);
        chk("reset discards pc", pc, RST_A);
        chk("reset discards flush", 32'(flush), 0);
        idle(4);
        chk("no late jump", pc, 32'd16);

        step(0, 0, 1, 32'hFFFF_FFF8, 0, 0);
        idle(1);
        chk("negative branch", pc, 32'h4);
        idle(2);

        step(0, 0, 0, 0, 1, 32'h202);
`ifdef PC_ALIGN_TRAP_EN
        chk("misalign pulse", 32'(misalign), 1);
`else
        chk("misalign tied", 32'(misalign), 0);
`endif
        idle(1);
`ifdef PC_ALIGN_TRAP_EN
        chk("trap vector", pc, TRAP);
`else
        chk("aligned target", pc, 32'h200);
`endif
        chk("misalign cleared", 32'(misalign), 0);

        idle(2);
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        idle(1);
        chk("wrap top", pc, 32'hFFFF_FFFC);
        idle(1);
        chk("wrap zero", pc, 32'h0);
        idle(4);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
